// File: rtl/ctrl_pipe_if.sv
// ctrl_pipe_if: ID-stage decode inputs and per-stage control outputs of the
// LEGv8 pipelined control unit. slave = control unit, master = datapath side.
interface ctrl_pipe_if #(
   parameter int OPW    = 11,
   parameter int REGW   = 5,
   parameter int ALUOPW = 3
);
   logic [OPW-1:0]    id_opcode;
   logic              id_valid;
   logic [REGW-1:0]   id_rd;
   logic [REGW-1:0]   id_rn;
   logic [REGW-1:0]   id_rm;
   logic [3:0]        id_cond;
   logic              id_regb_zero;
   logic [3:0]        ex_alu_flags;
   logic              id_reg2loc;
   logic              stall;
   logic              brtaken;
   logic              uncondbr;
   logic              ex_alusrc;
   logic [ALUOPW-1:0] ex_aluop;
   logic              ex_toadd;
   logic              mem_memread;
   logic              mem_memwrite;
   logic              wb_memtoreg;
   logic              wb_regwrite;
   logic [REGW-1:0]   wb_rd;
   logic [3:0]        flags_q;

   modport slave (
      input  id_opcode, id_valid, id_rd, id_rn, id_rm, id_cond, id_regb_zero, ex_alu_flags,
      output id_reg2loc, stall, brtaken, uncondbr, ex_alusrc, ex_aluop, ex_toadd,
             mem_memread, mem_memwrite, wb_memtoreg, wb_regwrite, wb_rd, flags_q
   );

   modport master (
      output id_opcode, id_valid, id_rd, id_rn, id_rm, id_cond, id_regb_zero, ex_alu_flags,
      input  id_reg2loc, stall, brtaken, uncondbr, ex_alusrc, ex_aluop, ex_toadd,
             mem_memread, mem_memwrite, wb_memtoreg, wb_regwrite, wb_rd, flags_q
   );
endinterface

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: pipelined control for the 5-stage LEGv8 core. Decodes in ID,
// resolves branches in ID with EX->ID flag forwarding, stalls one cycle on
// load-use, and carries EX/MEM/WB control through valid-tagged registers.
// Optional macro CTRL_PIPE_BCOND_EN: full B.cond condition decode; without it
// every B.cond tests LT as the N flag alone.
module ctrl_pipe #(
   parameter int OPW    = 11,
   parameter int REGW   = 5,
   parameter int ALUOPW = 3
) (
   input  logic        clk,
   input  logic        reset,
   ctrl_pipe_if.slave  bus
);
   localparam int STAGES = 3;                      // EX, MEM, WB
   localparam logic [REGW-1:0] XZR = {REGW{1'b1}};

   typedef struct packed {
      logic              alusrc;
      logic [ALUOPW-1:0] aluop;
      logic              toadd;
      logic              flagen;
   } ex_ctl_t;

   typedef struct packed {
      logic memread;
      logic memwrite;
   } mem_ctl_t;

   typedef struct packed {
      logic memtoreg;
      logic regwrite;
   } wb_ctl_t;

   // decode outputs
   ex_ctl_t  d_ex;
   mem_ctl_t d_mem;
   wb_ctl_t  d_wb;
   logic     d_reg2loc, d_uncond, d_bcond, d_cbz, d_use_rn, d_use_rb;

   // pipeline state; vld_pipe[1]=EX, [2]=MEM, [3]=WB
   logic [STAGES:1] vld_pipe;
   ex_ctl_t         ex_ex;
   mem_ctl_t        ex_mem, mem_mem;
   wb_ctl_t         ex_wb, mem_wb, wb_wb;
   logic [REGW-1:0] ex_rd, mem_rd, wb_rd_q;
   logic [3:0]      flags_r;

   logic            id_go, hit, cond_ok;
   logic [REGW-1:0] rb_sel;
   logic [3:0]      eff_flags;

   // opcode decode; unlisted opcodes fall through as an all-zero NOP
   always_comb begin
      d_ex      = '0;
      d_mem     = '0;
      d_wb      = '0;
      d_reg2loc = 1'b0;
      d_uncond  = 1'b0;
      d_bcond   = 1'b0;
      d_cbz     = 1'b0;
      d_use_rn  = 1'b0;
      d_use_rb  = 1'b0;
      casez (bus.id_opcode)
         11'b1001000100?: begin                       // ADDI
            d_ex.alusrc = 1'b1; d_ex.toadd = 1'b1; d_ex.aluop = ALUOPW'(3'b010);
            d_wb.regwrite = 1'b1; d_use_rn = 1'b1;
         end
         11'b10101011000: begin                       // ADDS
            d_ex.flagen = 1'b1; d_ex.aluop = ALUOPW'(3'b010); d_reg2loc = 1'b1;
            d_wb.regwrite = 1'b1; d_use_rn = 1'b1; d_use_rb = 1'b1;
         end
         11'b10001010000: begin                       // AND
            d_ex.aluop = ALUOPW'(3'b100); d_reg2loc = 1'b1;
            d_wb.regwrite = 1'b1; d_use_rn = 1'b1; d_use_rb = 1'b1;
         end
         11'b11001010000: begin                       // EOR
            d_ex.aluop = ALUOPW'(3'b110); d_reg2loc = 1'b1;
            d_wb.regwrite = 1'b1; d_use_rn = 1'b1; d_use_rb = 1'b1;
         end
         11'b11101011000: begin                       // SUBS
            d_ex.flagen = 1'b1; d_ex.aluop = ALUOPW'(3'b011); d_reg2loc = 1'b1;
            d_wb.regwrite = 1'b1; d_use_rn = 1'b1; d_use_rb = 1'b1;
         end
         11'b11010011010: begin                       // LSR
            d_ex.aluop = ALUOPW'(3'b111); d_wb.regwrite = 1'b1; d_use_rn = 1'b1;
         end
         11'b11111000010: begin                       // LDUR
            d_ex.alusrc = 1'b1; d_ex.aluop = ALUOPW'(3'b010); d_mem.memread = 1'b1;
            d_wb.memtoreg = 1'b1; d_wb.regwrite = 1'b1; d_use_rn = 1'b1;
         end
         11'b11111000000: begin                       // STUR (data read via Rd port)
            d_ex.alusrc = 1'b1; d_ex.aluop = ALUOPW'(3'b010); d_mem.memwrite = 1'b1;
            d_use_rn = 1'b1; d_use_rb = 1'b1;
         end
         11'b000101?????: d_uncond = 1'b1;            // B
         11'b01010100???: d_bcond  = 1'b1;            // B.cond
         11'b10110100???: begin                       // CBZ, tests Rt on the Rd port
            d_cbz = 1'b1; d_use_rb = 1'b1;
         end
         default: ;
      endcase
   end

   // load-use detection against the instruction currently in EX
   always_comb begin
      rb_sel = d_reg2loc ? bus.id_rm : bus.id_rd;
      hit    = (d_use_rn & (ex_rd == bus.id_rn)) | (d_use_rb & (ex_rd == rb_sel));
      bus.stall = bus.id_valid & vld_pipe[1] & ex_mem.memread & (ex_rd != XZR) & hit;
      id_go     = bus.id_valid & ~bus.stall;
   end

   // a flag setter in EX forwards its live flags to a B.cond in ID
   assign eff_flags = (vld_pipe[1] & ex_ex.flagen) ? bus.ex_alu_flags : flags_r;

`ifdef CTRL_PIPE_BCOND_EN
   function automatic logic cond_true(input logic [3:0] f, input logic [3:0] c);
      logic n, z, cf, v;
      {n, z, cf, v} = f;
      case (c)
         4'h0:    return z;
         4'h1:    return ~z;
         4'h2:    return cf;
         4'h3:    return ~cf;
         4'h4:    return n;
         4'h5:    return ~n;
         4'h6:    return v;
         4'h7:    return ~v;
         4'h8:    return cf & ~z;
         4'h9:    return ~(cf & ~z);
         4'hA:    return n == v;
         4'hB:    return n != v;
         4'hC:    return ~z & (n == v);
         4'hD:    return ~(~z & (n == v));
         default: return 1'b1;                        // AL, NV
      endcase
   endfunction

   assign cond_ok = cond_true(eff_flags, bus.id_cond);
`else
   // reduced build: every B.cond behaves as B.LT on N alone
   logic unused_cond;
   assign cond_ok     = eff_flags[3];
   assign unused_cond = ^{bus.id_cond, eff_flags[2:0]};
`endif

   // branch resolution in ID; a stall suppresses any redirect
   always_comb begin
      bus.brtaken    = id_go & (d_uncond | (d_cbz & bus.id_regb_zero) | (d_bcond & cond_ok));
      bus.uncondbr   = d_uncond;
      bus.id_reg2loc = d_reg2loc;
   end

   // stage registers: EX takes decode or a bubble, MEM/WB shift down
   always_ff @(posedge clk) begin
      if (reset) begin
         vld_pipe <= '0;
         ex_ex    <= '0;
         ex_mem   <= '0;
         ex_wb    <= '0;
         ex_rd    <= '0;
         mem_mem  <= '0;
         mem_wb   <= '0;
         mem_rd   <= '0;
         wb_wb    <= '0;
         wb_rd_q  <= '0;
      end else begin
         vld_pipe <= {vld_pipe[STAGES-1:1], id_go};
         ex_ex    <= id_go ? d_ex  : '0;
         ex_mem   <= id_go ? d_mem : '0;
         ex_wb    <= id_go ? d_wb  : '0;
         ex_rd    <= (id_go & d_wb.regwrite) ? bus.id_rd : '0;
         mem_mem  <= vld_pipe[1] ? ex_mem : '0;
         mem_wb   <= vld_pipe[1] ? ex_wb  : '0;
         mem_rd   <= vld_pipe[1] ? ex_rd  : '0;
         wb_wb    <= vld_pipe[2] ? mem_wb : '0;
         wb_rd_q  <= vld_pipe[2] ? mem_rd : '0;
      end
   end

   // architectural flags update only from a valid flag setter in EX
   always_ff @(posedge clk) begin
      if (reset)
         flags_r <= '0;
      else if (vld_pipe[1] & ex_ex.flagen)
         flags_r <= bus.ex_alu_flags;
   end

   // stage outputs are zero whenever the stage holds no valid instruction
   always_comb begin
      bus.ex_alusrc    = vld_pipe[1] & ex_ex.alusrc;
      bus.ex_aluop     = vld_pipe[1] ? ex_ex.aluop : '0;
      bus.ex_toadd     = vld_pipe[1] & ex_ex.toadd;
      bus.mem_memread  = vld_pipe[2] & mem_mem.memread;
      bus.mem_memwrite = vld_pipe[2] & mem_mem.memwrite;
      bus.wb_memtoreg  = vld_pipe[3] & wb_wb.memtoreg;
      bus.wb_regwrite  = vld_pipe[3] & wb_wb.regwrite;
      bus.wb_rd        = vld_pipe[3] ? wb_rd_q : '0;
      bus.flags_q      = flags_r;
   end
endmodule
